// File: rtl/ysyx_22050243_pkg.sv
// Shared decode constants for the core: opcodes, funct3 access encodings,
// and the load/store unit state type plus its byte-lane mask helper.
package ysyx_22050243_pkg;

    localparam int LSU_XLEN = 64;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // funct3[1:0] encodes access size for both loads and stores.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22050243_lsu_align.sv
// Combinational lane logic: store data/mask placement from the live request,
// and load lane extraction with sign/zero extension from the captured request.
module ysyx_22050243_lsu_align
    import ysyx_22050243_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [2:0]  st_off,
    input  logic [63:0] st_wdata_in,
    output logic [63:0] st_wdata,
    output logic [7:0]  st_wmask,
    output logic        aligned,
    input  logic [2:0]  ld_funct3,
    input  logic [2:0]  ld_off,
    input  logic [63:0] ld_rdata,
    output logic [63:0] ld_data
);

    logic [63:0] shifted;

    always_comb begin
        st_wdata = st_wdata_in << {st_off, 3'b000};
        st_wmask = size_mask(st_size) << st_off;
        case (st_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~st_off[0];
            2'b10:   aligned = (st_off[1:0] == 2'b00);
            default: aligned = (st_off == 3'b000);
        endcase
    end

    always_comb begin
        shifted = ld_rdata >> {ld_off, 3'b000};
        case (ld_funct3)
            F3_LB:   ld_data = {{56{shifted[7]}}, shifted[7:0]};
            F3_LH:   ld_data = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   ld_data = {{32{shifted[31]}}, shifted[31:0]};
            F3_LBU:  ld_data = {56'b0, shifted[7:0]};
            F3_LHU:  ld_data = {48'b0, shifted[15:0]};
            F3_LWU:  ld_data = {32'b0, shifted[31:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22050243_lsu.sv
// Load/store unit: one bus transaction per memory instruction, stalling the
// core until the response (load data or write ack) arrives.
module ysyx_22050243_lsu
    import ysyx_22050243_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              lsu_stall,
    output logic              lsu_done,
    output logic [XLEN-1:0]   load_data,
    output logic              misalign,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [XLEN-1:0]   req_wdata,
    output logic [7:0]        req_wmask,
    input  logic              rsp_valid,
    input  logic [XLEN-1:0]   rsp_rdata,
    output logic [1:0]        dbg_state
);

    // Handshake: a request transfers on a cycle with req_valid & req_ready;
    // req_* hold steady from the capture edge until that cycle. A response
    // counts only when rsp_valid is seen in WAIT or alongside the accept.

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [7:0]        wmask_q, wmask_d;
    logic [XLEN-1:0]   load_q, load_d;

    logic              access;
    logic              aligned;
    logic              start;
    logic              rsp_take;
    logic [63:0]       st_wdata;
    logic [7:0]        st_wmask;
    logic [63:0]       ld_data;

    ysyx_22050243_lsu_align u_align (
        .st_size     (funct3[1:0]),
        .st_off      (addr[2:0]),
        .st_wdata_in (wdata),
        .st_wdata    (st_wdata),
        .st_wmask    (st_wmask),
        .aligned     (aligned),
        .ld_funct3   (f3_q),
        .ld_off      (addr_q[2:0]),
        .ld_rdata    (rsp_rdata),
        .ld_data     (ld_data)
    );

    assign access   = mem_r | mem_w;
    assign start    = ~rst & (state_q == IDLE) & access & aligned;
    assign rsp_take = rsp_valid & (((state_q == REQ) & req_ready) | (state_q == WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (req_ready) state_d = rsp_valid ? DONE : WAIT;
            WAIT:    if (rsp_valid) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // A load wins when the decoder raises both mem_r and mem_w.
    always_comb begin
        addr_d  = addr_q;
        f3_d    = f3_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        load_d  = load_q;
        if (start) begin
            addr_d  = addr;
            f3_d    = funct3;
            we_d    = ~mem_r;
            wdata_d = st_wdata;
            wmask_d = mem_r ? 8'h00 : st_wmask;
        end
        if (rsp_take) begin
            load_d = we_q ? '0 : ld_data;
        end
    end

    always_comb begin
        req_valid = (state_q == REQ);
        lsu_done  = (state_q == DONE);
        lsu_stall = start | (state_q == REQ) | (state_q == WAIT);
        misalign  = ~rst & (state_q == IDLE) & access & ~aligned;
        req_we    = we_q;
        req_addr  = {addr_q[ADDR_W-1:3], 3'b000};
        req_wdata = wdata_q;
        req_wmask = wmask_q;
        load_data = load_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
// Directed bench for the load/store unit: a driver issues vectors and pushes
// expected requests/results; a negedge monitor pops and compares them.
module tb_ysyx_22050243_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r;
    logic        mem_w;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic [63:0] load_data;
    logic        misalign;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        r;
        logic        w;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [3:0]  ready_lat;
        logic [3:0]  rsp_lat;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_mask;
        logic [63:0] exp_load;
    } vec_t;

    vec_t vecs [12];

    // {we, addr, wdata, wmask}
    logic [136:0] exp_req_q[$];
    logic [63:0]  exp_q[$];

    ysyx_22050243_lsu #(.XLEN(64), .ADDR_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_r     (mem_r),
        .mem_w     (mem_w),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .lsu_stall (lsu_stall),
        .lsu_done  (lsu_done),
        .load_data (load_data),
        .misalign  (misalign),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready) begin
                if (exp_req_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req actual=addr %h expected=none", req_addr);
                end else begin
                    logic [136:0] e;
                    e = exp_req_q.pop_front();
                    check("req_we",    {63'b0, req_we}, {63'b0, e[136]});
                    check("req_addr",  req_addr,  e[135:72]);
                    check("req_wdata", req_wdata, e[71:8]);
                    check("req_wmask", {56'b0, req_wmask}, {56'b0, e[7:0]});
                end
            end
            if (lsu_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done actual=%h expected=none", load_data);
                end else begin
                    check("load_data", load_data, exp_q.pop_front());
                end
            end
        end
    end

    // driver tasks
    task automatic run_vec(input vec_t v);
        logic [63:0] ea;
        bit got;
        ea = v.addr & ~64'h7;
        mem_r  = v.r;
        mem_w  = v.w;
        funct3 = v.f3;
        addr   = v.addr;
        wdata  = v.wdata;
        exp_req_q.push_back({~v.r, ea, v.exp_wdata, v.exp_mask});
        exp_q.push_back(v.exp_load);
        @(negedge clk);
        check("start_stall", {63'b0, lsu_stall}, 64'd1);
        @(posedge clk) #1;
        mem_r = 1'b0;
        mem_w = 1'b0;
        addr  = 64'h5555_5555_5555_5555;
        wdata = 64'hAAAA_AAAA_AAAA_AAAA;
        for (int i = 0; i < int'(v.ready_lat); i++) begin
            @(negedge clk);
            check("hold_valid", {63'b0, req_valid}, 64'd1);
            check("hold_stall", {63'b0, lsu_stall}, 64'd1);
            check("hold_addr",  req_addr, ea);
            check("hold_wdata", req_wdata, v.exp_wdata);
            check("hold_wmask", {56'b0, req_wmask}, {56'b0, v.exp_mask});
            @(posedge clk) #1;
        end
        req_ready = 1'b1;
        if (v.rsp_lat == 0) begin
            rsp_valid = 1'b1;
            rsp_rdata = v.rdata;
        end
        @(posedge clk) #1;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        if (v.rsp_lat != 0) begin
            for (int i = 0; i < int'(v.rsp_lat) - 1; i++) begin
                @(negedge clk);
                check("wait_stall", {63'b0, lsu_stall}, 64'd1);
                check("wait_novalid", {63'b0, req_valid}, 64'd0);
                @(posedge clk) #1;
            end
            rsp_valid = 1'b1;
            rsp_rdata = v.rdata;
            @(posedge clk) #1;
            rsp_valid = 1'b0;
            rsp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (lsu_done) got = 1'b1;
        end
        check("done_seen", {63'b0, got}, 64'd1);
        check("done_stall", {63'b0, lsu_stall}, 64'd0);
        @(posedge clk) #1;
    endtask

    task automatic run_misalign(input logic [2:0] f3, input logic [63:0] a);
        mem_r  = 1'b1;
        mem_w  = 1'b0;
        funct3 = f3;
        addr   = a;
        @(negedge clk);
        check("misalign_pulse", {63'b0, misalign}, 64'd1);
        check("misalign_nostall", {63'b0, lsu_stall}, 64'd0);
        @(posedge clk) #1;
        mem_r = 1'b0;
        @(negedge clk);
        check("misalign_idle", {62'b0, dbg_state}, 64'd0);
        check("misalign_noreq", {63'b0, req_valid}, 64'd0);
        check("misalign_drop", {63'b0, misalign}, 64'd0);
        @(posedge clk) #1;
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        //            r     w     f3     addr                   wdata                  rdata                  rl    sl    exp_wdata              mask   exp_load
        vecs[0]  = '{1'b1, 1'b0, 3'd3, 64'h0000_0000_8000_0010, 64'h0, 64'h1122_3344_5566_7788, 4'd0, 4'd1, 64'h0, 8'h00, 64'h1122_3344_5566_7788};
        vecs[1]  = '{1'b1, 1'b0, 3'd0, 64'h0000_0000_8000_0003, 64'h0, 64'h0000_0000_8000_0000, 4'd0, 4'd1, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[2]  = '{1'b1, 1'b0, 3'd4, 64'h0000_0000_8000_0003, 64'h0, 64'h0000_0000_8000_0000, 4'd1, 4'd2, 64'h0, 8'h00, 64'h0000_0000_0000_0080};
        vecs[3]  = '{1'b0, 1'b1, 3'd1, 64'h0000_0000_8000_0006, 64'hABCD, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 4'd2, 64'hABCD_0000_0000_0000, 8'hC0, 64'h0};
        vecs[4]  = '{1'b0, 1'b1, 3'd2, 64'h0000_0000_8000_0004, 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 4'd1, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'h0};
        vecs[5]  = '{1'b1, 1'b0, 3'd1, 64'h0000_0000_8000_0022, 64'h0, 64'h0000_0000_8001_1234, 4'd5, 4'd1, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_8001};
        vecs[6]  = '{1'b1, 1'b0, 3'd6, 64'h0000_0000_8000_0104, 64'h0, 64'hF0E0_D0C0_0000_0000, 4'd0, 4'd0, 64'h0, 8'h00, 64'h0000_0000_F0E0_D0C0};
        vecs[7]  = '{1'b1, 1'b0, 3'd2, 64'h0000_0000_8000_0104, 64'h0, 64'hF0E0_D0C0_0000_0000, 4'd2, 4'd0, 64'h0, 8'h00, 64'hFFFF_FFFF_F0E0_D0C0};
        vecs[8]  = '{1'b1, 1'b0, 3'd5, 64'h0000_0000_8000_0006, 64'h0, 64'hBEEF_0000_0000_0000, 4'd0, 4'd3, 64'h0, 8'h00, 64'h0000_0000_0000_BEEF};
        vecs[9]  = '{1'b0, 1'b1, 3'd0, 64'h0000_0000_8000_0007, 64'h9A, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 4'd0, 64'h9A00_0000_0000_0000, 8'h80, 64'h0};
        vecs[10] = '{1'b0, 1'b1, 3'd3, 64'h0000_0000_8000_0008, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 4'd1, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0};
        vecs[11] = '{1'b1, 1'b1, 3'd3, 64'h0000_0000_8000_0040, 64'h0, 64'h0000_0000_0000_CAFE, 4'd0, 4'd1, 64'h0, 8'h00, 64'h0000_0000_0000_CAFE};

        rst       = 1'b1;
        mem_r     = 1'b0;
        mem_w     = 1'b0;
        funct3    = 3'd0;
        addr      = 64'h0;
        wdata     = 64'h0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_state", {62'b0, dbg_state}, 64'd0);
        check("rst_stall", {63'b0, lsu_stall}, 64'd0);
        check("rst_valid", {63'b0, req_valid}, 64'd0);
        check("rst_done", {63'b0, lsu_done}, 64'd0);
        check("rst_load", load_data, 64'd0);
        check("rst_wmask", {56'b0, req_wmask}, 64'd0);
        @(posedge clk) #1;

        run_vec(vecs[0]);

        // stale response in IDLE must not produce a completion
        rsp_valid = 1'b1;
        rsp_rdata = 64'h1234;
        @(posedge clk) #1;
        rsp_valid = 1'b0;
        @(negedge clk);
        check("stale_idle_done", {63'b0, lsu_done}, 64'd0);
        check("stale_idle_state", {62'b0, dbg_state}, 64'd0);
        @(posedge clk) #1;

        for (int i = 1; i <= 3; i++) run_vec(vecs[i]);
        run_misalign(3'd2, 64'h0000_0000_8000_0002);
        run_misalign(3'd3, 64'h0000_0000_8000_0004);
        run_misalign(3'd1, 64'h0000_0000_8000_0001);
        for (int i = 4; i < 12; i++) run_vec(vecs[i]);

        // reset while waiting for the response
        mem_r  = 1'b1;
        mem_w  = 1'b0;
        funct3 = 3'd3;
        addr   = 64'h0000_0000_8000_0200;
        wdata  = 64'h0;
        exp_req_q.push_back({1'b0, 64'h0000_0000_8000_0200, 64'h0, 8'h00});
        @(posedge clk) #1;
        mem_r     = 1'b0;
        req_ready = 1'b1;
        @(posedge clk) #1;
        req_ready = 1'b0;
        @(negedge clk);
        check("rstw_wait_stall", {63'b0, lsu_stall}, 64'd1);
        check("rstw_wait_state", {62'b0, dbg_state}, 64'd2);
        @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstw_state", {62'b0, dbg_state}, 64'd0);
        check("rstw_stall", {63'b0, lsu_stall}, 64'd0);
        check("rstw_valid", {63'b0, req_valid}, 64'd0);
        check("rstw_addr", req_addr, 64'd0);
        check("rstw_load", load_data, 64'd0);
        @(posedge clk) #1;
        rsp_valid = 1'b1;
        rsp_rdata = 64'h7777;
        @(posedge clk) #1;
        rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_rsp_done", {63'b0, lsu_done}, 64'd0);
        end
        @(posedge clk) #1;

        check("req_q_drained", 64'(exp_req_q.size()), 64'd0);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
